// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, controller states and the divide-by-zero quotient.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PREP = 2'b01,
    RUN  = 2'b10,
    FIX  = 2'b11
  } state_e;

  // Quotient returned on divide by zero; sliced to WIDTH by the user.
  localparam logic [63:0] DIV0_LO = {64{1'b1}};

endpackage

// File: rtl/muldiv_iter_core.sv
// RUN-phase datapath: one shift-add (multiply) or restoring-subtract
// (divide) step per cycle on a 2*WIDTH accumulator, plus the step counter.
// Operands arrive already made non-negative by the controller.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 step,
  input  logic                 is_div,
  input  logic [WIDTH-1:0]     opa,
  input  logic [WIDTH-1:0]     opb,
  output logic [2*WIDTH-1:0]   acc,
  output logic                 last
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     rsh_s;
  logic [WIDTH:0]     trial_s;

  // Step arithmetic: multiply adds the multiplicand into the upper half when
  // the current multiplier bit is set; divide trial-subtracts the divisor
  // from the partial remainder with the next dividend bit shifted in.
  always_comb begin
    sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    rsh_s   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial_s = rsh_s - {1'b0, opnd_q};
  end

  // Next accumulator / operand / counter: load in PREP, iterate in RUN.
  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    if (load) begin
      acc_d  = {{WIDTH{1'b0}}, opa};
      opnd_d = opb;
      cnt_d  = CNT_W'(WIDTH);
    end else if (step) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (is_div) begin
        if (!trial_s[WIDTH]) begin
          acc_d = {trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {rsh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = {sum_s, acc_q[WIDTH-1:1]};
      end
    end else begin
      acc_d  = acc_q;
      opnd_d = opnd_q;
      cnt_d  = cnt_q;
    end
  end

  // Datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q  <= {(2*WIDTH){1'b0}};
      opnd_q <= {WIDTH{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign acc  = acc_q;
  // The step taken while the counter reads 1 is the final one.
  assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers,
// MTHI/MTLO writes and a start/busy/done handshake. Sign handling and the
// HI/LO registers live here; the per-bit datapath is in muldiv_iter_core.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero
);

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               res_neg_q, res_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               bzero_q, bzero_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               signed_s, neg_a_s, neg_b_s;
  logic [WIDTH-1:0]   abs_a_s, abs_b_s;
  logic [2*WIDTH-1:0] acc_s, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;
  logic               last_s;

  muldiv_iter_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (state_q == PREP),
    .step    (state_q == RUN),
    .is_div  (op_q[1]),
    .opa     (abs_a_s),
    .opb     (abs_b_s),
    .acc     (acc_s),
    .last    (last_s)
  );

  // Operand magnitudes for PREP and sign-corrected results for FIX.
  always_comb begin
    signed_s = (op_q == OP_MULT) || (op_q == OP_DIV);
    neg_a_s  = signed_s & a_q[WIDTH-1];
    neg_b_s  = signed_s & b_q[WIDTH-1];
    abs_a_s  = neg_a_s ? (-a_q) : a_q;
    abs_b_s  = neg_b_s ? (-b_q) : b_q;
    prod_s   = res_neg_q ? (-acc_s) : acc_s;
    quo_s    = res_neg_q ? (-acc_s[WIDTH-1:0]) : acc_s[WIDTH-1:0];
    rem_s    = rem_neg_q ? (-acc_s[2*WIDTH-1:WIDTH]) : acc_s[2*WIDTH-1:WIDTH];
  end

  // Controller next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = PREP;
        else       state_d = IDLE;
      end
      PREP: state_d = RUN;
      RUN: begin
        if (last_s) state_d = FIX;
        else        state_d = RUN;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Controller outputs and architectural register updates per state.
  always_comb begin
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    bzero_d   = bzero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // start wins over a simultaneous MTHI/MTLO
          op_d  = op;
          a_d   = a;
          b_d   = b;
          dbz_d = 1'b0;
        end else begin
          if (hi_we) hi_d = wdata;
          else       hi_d = hi_q;
          if (lo_we) lo_d = wdata;
          else       lo_d = lo_q;
        end
      end
      PREP: begin
        res_neg_d = neg_a_s ^ neg_b_s;
        rem_neg_d = neg_a_s;
        bzero_d   = (b_q == {WIDTH{1'b0}});
      end
      RUN: begin
        hi_d = hi_q;
        lo_d = lo_q;
      end
      FIX: begin
        done_d = 1'b1;
        if (op_q[1]) begin
          // zero divisor: quotient is all ones, remainder path yields a
          if (bzero_q) lo_d = DIV0_LO[WIDTH-1:0];
          else         lo_d = quo_s;
          hi_d  = rem_s;
          dbz_d = bzero_q;
        end else begin
          {hi_d, lo_d} = prod_s;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
    busy_d = (state_d == RUN) || (state_d == FIX);
  end

  // All controller and architectural state, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      op_q      <= 2'b00;
      a_q       <= {WIDTH{1'b0}};
      b_q       <= {WIDTH{1'b0}};
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      bzero_q   <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      bzero_q   <= bzero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign zero        = ({hi_q, lo_q} == {(2*WIDTH){1'b0}});

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit for the MIPS datapath. It is the successor to the single-cycle combinational signed multiplier, and it adds the following:
- width parameter
- signed and unsigned MULT and DIV
- architectural HI/LO registers with MTHI/MTLO writes
- start/busy/done handshake

The unit sits beside the main ALU. The controller stalls MFHI/MFLO while busy=1.

Parameters:
WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; product is 2*WIDTH.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous active-low reset
start  in  1  begin operation; sampled only in IDLE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  in  WIDTH  rs operand (multiplicand / dividend)
b  in  WIDTH  rt operand (multiplier / divisor)
hi_we  in  1  MTHI write enable
lo_we  in  1  MTLO write enable
wdata  in  WIDTH  MTHI/MTLO data
busy  out  1  operation in progress
done  out  1  one-cycle pulse when HI/LO are updated by an operation
div_by_zero  out  1  sticky flag set by DIV/DIVU with b==0; cleared by next accepted start
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
zero  out  1  ({hi,lo} == 0), combinational from registers

Behaviour:
- Reset (reset_n==0 at a rising edge) takes priority over all other events:
  - state goes to IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0.
  - Reset mid-operation aborts the operation; no done pulse follows.
- States and transitions:
  - IDLE: start=1 latches op, a and b at edge N, then go to PREP.
  - PREP: one cycle. For signed ops, store |a|, |b| and the result-sign bits. Load the counter with WIDTH. Go to RUN.
  - RUN: one bit per cycle for WIDTH cycles; when the counter reaches 0, go to FIX.
    - Multiply: shift-add into a 2*WIDTH accumulator.
    - Divide: restoring divide, giving remainder:quotient.
  - FIX: apply sign correction, write HI/LO, assert done for exactly one cycle, return to IDLE.
- Timing:
  - busy=1 from edge N+1 until HI/LO are written at edge N+WIDTH+2.
  - done=1 and busy=0 in the cycle after edge N+WIDTH+2.
  - Total latency is WIDTH+2 cycles (34 for WIDTH=32).
- MULT/MULTU: {hi,lo} = full 2*WIDTH product. MULT is signed × signed; MULTU is unsigned × unsigned.
- DIV/DIVU: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Signed overflow (most-negative / -1): lo = 0x80000000, hi = 0; no flag raised.
- Divide by zero: no iteration is skipped and timing is identical.
  - Result: lo = all ones, hi = a.
  - div_by_zero set in the same cycle as done.
- start while busy: ignored; no queueing.
- hi_we/lo_we:
  - In IDLE, write wdata at the next edge; hi_we and lo_we may both be set.
  - While busy, writes are ignored.
  - start together with hi_we/lo_we in IDLE: start wins and the writes are dropped.
- HI/LO hold their previous values throughout RUN. Intermediate values are never visible on hi/lo.
- Inputs a/b may change after the start edge without affecting the result.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state enum IDLE/PREP/RUN/FIX
  - DIV0_LO constant (all ones)
- One natural sub-module: muldiv_iter_core. It holds the RUN datapath (shift-add / restoring-subtract step, accumulator, counter) and is controlled by the FSM in muldiv_unit. The sign handling and HI/LO registers stay in the top module.

Test Plan:
- Reset mid-RUN: start MULT, deassert reset_n at cycle 10 -> hi=lo=0, busy=0, no done pulse; next start runs normally.
- MULT a=0xFFFFFFFE (-2), b=0x00000003 -> after 34 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse of 1 cycle. MULTU on the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=7, b=2 -> lo=3, hi=1. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1 with done; next start clears div_by_zero.
- Handshake:
  - start pulsed again at cycle 5 of a busy MULTU -> ignored; result is that of the first operation only.
  - hi_we with wdata=0xDEAD while busy -> hi unchanged.
  - hi_we in IDLE -> hi=0xDEAD next cycle.
  - start+lo_we in the same IDLE cycle -> lo_we dropped.
- zero flag: MULT a=0, b=5 -> zero=1 after done. MTLO wdata=1 -> zero=0.
